// File: rtl/arc4_sched_if.sv
// arc4_sched_if -- bundle of every non-clock/reset signal of arc4_sched.
//
// Signals:
//   en / rdy / err / phase        upstream start handshake, sticky timeout
//                                 flag and active-phase indicator
//   <x>_en / <x>_rdy              start strobe and ready flag per engine
//                                 (x = init, ksa, prga)
//   <x>_addr / <x>_wrdata / <x>_wren
//                                 S-memory request from each engine
//   s_addr / s_wrdata / s_wren    arbitrated single-port S-memory request
//
// Modports:
//   slave  : the sequencer's view (arc4_sched)
//   master : the surrounding logic's view (upstream controller + engines)
interface arc4_sched_if;
  logic       en;
  logic       rdy;
  logic       err;
  logic [1:0] phase;

  logic       init_en;
  logic       ksa_en;
  logic       prga_en;
  logic       init_rdy;
  logic       ksa_rdy;
  logic       prga_rdy;

  logic [7:0] init_addr;
  logic [7:0] ksa_addr;
  logic [7:0] prga_addr;
  logic [7:0] init_wrdata;
  logic [7:0] ksa_wrdata;
  logic [7:0] prga_wrdata;
  logic       init_wren;
  logic       ksa_wren;
  logic       prga_wren;

  logic [7:0] s_addr;
  logic [7:0] s_wrdata;
  logic       s_wren;

  modport slave (
    input  en,
    input  init_rdy, ksa_rdy, prga_rdy,
    input  init_addr, ksa_addr, prga_addr,
    input  init_wrdata, ksa_wrdata, prga_wrdata,
    input  init_wren, ksa_wren, prga_wren,
    output rdy, err, phase,
    output init_en, ksa_en, prga_en,
    output s_addr, s_wrdata, s_wren
  );

  modport master (
    output en,
    output init_rdy, ksa_rdy, prga_rdy,
    output init_addr, ksa_addr, prga_addr,
    output init_wrdata, ksa_wrdata, prga_wrdata,
    output init_wren, ksa_wren, prga_wren,
    input  rdy, err, phase,
    input  init_en, ksa_en, prga_en,
    input  s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/arc4_sched.sv
// arc4_sched -- phase sequencer and S-memory arbiter for the ARC4 core.
//
// One accepted start request runs the init, KSA and PRGA engines strictly
// in that order. While a phase is active, that engine owns the single-port
// S-memory: its address, write data and write enable are muxed onto s_*.
// Upstream sees the same en/rdy handshake an individual engine offers.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    arc4_sched_if.slave (handshake, engine strobes/flags, memory mux)
//
// Parameters:
//   TIMEOUT_CYCLES  cycle limit for a single phase (timeout build only)
//
// Optional feature: define ARC4_SCHED_TIMEOUT_EN to build the per-phase
// watchdog. A phase that runs TIMEOUT_CYCLES cycles is aborted back to IDLE
// and err is set (sticky until the next accepted en). Without the macro err
// is tied low and a hung engine stalls the sequencer.
module arc4_sched #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  arc4_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT_GO   = 3'd1,
    INIT_WAIT = 3'd2,
    KSA_GO    = 3'd3,
    KSA_WAIT  = 3'd4,
    PRGA_GO   = 3'd5,
    PRGA_WAIT = 3'd6
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic       seen_low_reg;
  logic       seen_low_next;

  logic [1:0] phase_int;
  logic       in_go;
  logic       in_wait;
  logic       owner_rdy;

  // Engine request tables indexed by phase. Slot 0 is the idle "owner":
  // all zeros, so IDLE drives s_* to 0 and no wren can leak through.
  logic [3:0] eng_rdy;
  logic [7:0] eng_addr   [4];
  logic [7:0] eng_wrdata [4];
  logic [3:0] eng_wren;

  assign eng_rdy       = {bus.prga_rdy, bus.ksa_rdy, bus.init_rdy, 1'b0};
  assign eng_wren      = {bus.prga_wren, bus.ksa_wren, bus.init_wren, 1'b0};
  assign eng_addr[0]   = 8'h00;
  assign eng_addr[1]   = bus.init_addr;
  assign eng_addr[2]   = bus.ksa_addr;
  assign eng_addr[3]   = bus.prga_addr;
  assign eng_wrdata[0] = 8'h00;
  assign eng_wrdata[1] = bus.init_wrdata;
  assign eng_wrdata[2] = bus.ksa_wrdata;
  assign eng_wrdata[3] = bus.prga_wrdata;

`ifdef ARC4_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;
  logic             timeout_hit;
  logic             go_entry;
`endif

  // Next-state and phase decode.
  always_comb begin
    state_next    = state_reg;
    seen_low_next = seen_low_reg;
    phase_int     = 2'd0;
    in_go         = 1'b0;
    in_wait       = 1'b0;
`ifdef ARC4_SCHED_TIMEOUT_EN
    timeout_hit   = 1'b0;
    go_entry      = 1'b0;
`endif

    case (state_reg)
      INIT_GO:   begin phase_int = 2'd1; in_go   = 1'b1; end
      INIT_WAIT: begin phase_int = 2'd1; in_wait = 1'b1; end
      KSA_GO:    begin phase_int = 2'd2; in_go   = 1'b1; end
      KSA_WAIT:  begin phase_int = 2'd2; in_wait = 1'b1; end
      PRGA_GO:   begin phase_int = 2'd3; in_go   = 1'b1; end
      PRGA_WAIT: begin phase_int = 2'd3; in_wait = 1'b1; end
      default:   ;
    endcase

    owner_rdy = eng_rdy[phase_int];

    if (state_reg == IDLE && bus.en) begin
      state_next = INIT_GO;
    end

    // GO -> WAIT once the engine is ready to take the strobe.
    if (in_go && owner_rdy) begin
      state_next = state_t'(state_reg + 3'd1);
    end

    // The engine keeps rdy high for the first WAIT cycle, so completion
    // is only trusted after rdy has been observed low in this WAIT.
    if (in_wait && seen_low_reg && owner_rdy) begin
      state_next = (state_reg == PRGA_WAIT) ? IDLE : state_t'(state_reg + 3'd1);
    end

`ifdef ARC4_SCHED_TIMEOUT_EN
    if (phase_int != 2'd0 && cnt_reg == CNT_LIMIT) begin
      timeout_hit = 1'b1;
      state_next  = IDLE;
    end
    go_entry = (state_next != state_reg) &&
               (state_next == INIT_GO || state_next == KSA_GO || state_next == PRGA_GO);
`endif

    // The flag belongs to one WAIT visit; any state change clears it.
    if (state_next != state_reg) begin
      seen_low_next = 1'b0;
    end else if (in_wait && !owner_rdy) begin
      seen_low_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      seen_low_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      seen_low_reg <= seen_low_next;
    end
  end

`ifdef ARC4_SCHED_TIMEOUT_EN
  // Phase watchdog: restarts on each GO entry and keeps running through
  // the following WAIT, so it bounds the whole phase. It saturates at the
  // limit; the FSM leaves the phase on the next edge anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (go_entry) begin
        cnt_reg <= '0;
      end else if (phase_int != 2'd0 && cnt_reg != CNT_LIMIT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (state_reg == IDLE && bus.en) begin
        err_reg <= 1'b0;
      end else if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif

  // Moore outputs: decoded from the state register only.
  assign bus.rdy     = (state_reg == IDLE);
  assign bus.phase   = phase_int;
  assign bus.init_en = (state_reg == INIT_GO);
  assign bus.ksa_en  = (state_reg == KSA_GO);
  assign bus.prga_en = (state_reg == PRGA_GO);

  // Zero-latency memory mux; non-owner write enables never pass.
  assign bus.s_addr   = eng_addr[phase_int];
  assign bus.s_wrdata = eng_wrdata[phase_int];
  assign bus.s_wren   = eng_wren[phase_int];

endmodule

// File: doc/arc4_sched.md
# arc4_sched

Phase sequencer and S-memory arbiter for the ARC4 decryption core. A single top-level start request runs the init, KSA and PRGA engines in strict order, one at a time. The block owns the single-port 256×8 S-memory port and multiplexes the active engine's address, write data and write enable onto it. It exposes the same en/rdy handshake as the engines, so the next level up sees one engine.

## Interface
- TIMEOUT_CYCLES, 4096: maximum cycles a phase may run before being aborted; only used when the timeout feature is compiled in.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high while idle and able to accept en.
- err  out  1  sticky phase-timeout flag.
- phase  out  2  active phase: 0 idle, 1 init, 2 ksa, 3 prga.
- init_en, ksa_en, prga_en  out  1 each  engine start strobes.
- init_rdy, ksa_rdy, prga_rdy  in  1 each  engine ready flags.
- init_addr, ksa_addr, prga_addr  in  8 each  engine S-memory addresses.
- init_wrdata, ksa_wrdata, prga_wrdata  in  8 each  engine write data.
- init_wren, ksa_wren, prga_wren  in  1 each  engine write enables.
- s_addr  out  8  S-memory address.
- s_wrdata  out  8  S-memory write data.
- s_wren  out  1  S-memory write enable.

## Operation
- Registered Moore FSM with 7 states: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT.
- IDLE: rdy=1, phase=0, all x_en=0, s_addr=0, s_wrdata=0, s_wren=0.
  - en=1 at a posedge → INIT_GO.
  - en=0 holds IDLE.
- X_GO: drives x_en=1, rdy=0, phase=X.
  - x_rdy=1 at a posedge → X_WAIT. The engine has accepted the strobe.
  - x_rdy=0 stays in X_GO with x_en held high.
- X_WAIT: drives x_en=0.
  - x_rdy=1 at a posedge → next phase's GO state; PRGA_WAIT → IDLE.
  - The first WAIT cycle is never treated as completion, because the engine drops rdy the cycle after accepting en.
  - Implement this with a one-bit "seen low" flag set when x_rdy=0 in WAIT. Completion requires that flag set and x_rdy=1.
- Arbitration: the owner is the phase of the current state.
  - s_addr, s_wrdata and s_wren are combinational muxes of the owner's inputs.
  - Non-owner wren is masked and never reaches s_wren.
  - No owner in IDLE; memory outputs are 0.
- en asserted while rdy=0 is ignored, not queued.
- err clears when en is accepted in IDLE.

## Timing
- Reset values, applied asynchronously: state IDLE, rdy=1, err=0, phase=0, all x_en=0, s_wren=0, s_addr=0, s_wrdata=0, seen-low flag 0.
- Reset asserted mid-phase aborts immediately; the engine en drops in the same instant.
- en→init_en latency: 1 cycle.
- Phase handoff: an engine's rdy rising at edge N puts the next x_en high after edge N.
- The memory mux adds zero latency: an engine addr/wren change appears on s_* in the same cycle.
- Engine read data is not routed through this block; engines tap memory q directly.
- Overall: rdy returns high one cycle after the edge at which prga_rdy is seen high in PRGA_WAIT with the flag set.
- phase changes on the same edge as the state.

## Configuration
- ARC4_SCHED_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to each GO state and increments every cycle in GO or WAIT.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE on the next edge, sets err=1 and deasserts all x_en.
- Not defined: no counter is built; err is tied 0 and a hung engine stalls the FSM indefinitely.

## Test plan
- Reset: rst_n=0 mid-KSA_WAIT → rdy=1, phase=0, ksa_en=0, s_wren=0, all without waiting for a clock edge.
- Full run: engine models with 256/768/64-cycle busy periods and en pulsed once → phases 1, 2, 3 in order; each x_en high exactly 1 cycle; rdy returns 1 exactly 1 cycle after prga_rdy rises.
- Arbitration: init_wren=1 with addr 0x10 during INIT_WAIT while ksa_wren=1 with addr 0x20 → s_addr=0x10, s_wren=1. In KSA_WAIT, init_wren=1 alone → s_wren=0.
- Late acceptance: ksa_rdy held 0 for 5 cycles in KSA_GO → ksa_en stays 1 for 5+1 cycles; no advance to KSA_WAIT before then.
- Busy request: en pulsed during PRGA_WAIT → ignored; exactly one run completes and no second init_en follows.
- Timeout (macro on, TIMEOUT_CYCLES=16): ksa_rdy stuck 0 after acceptance → IDLE with err=1 at cycle 16 after KSA_GO entry; the next accepted en clears err.
